// File: rtl/board_port_arbiter.sv
// rtl/board_port_arbiter.sv - three-way arbiter for the board_state read port
//
// Shares the combinational board_state read port among the display renderer,
// the player-move legality check and the ghost-move AI. One grant per cycle;
// the granted address is registered onto mem_x/mem_y and the cell returned by
// board_state is captured one cycle later and pulsed out on <client>_valid.
//
// Optional feature macro: BOARD_ARB_STARVE_EN
//   defined   : player/ghost starvation counters force a long-waiting request
//               through ahead of the display.
//   undefined : strict priority display > round-robin(player, ghost).
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   disp_req/x/y -> disp_gnt/valid/data   display requester
//   pl_req/x/y   -> pl_gnt/valid/data     player requester
//   gh_req/x/y   -> gh_gnt/valid/data     ghost requester
//   mem_x, mem_y (out), mem_data (in)     board_state read port
//   busy                                  an access is in flight

module board_port_arbiter #(
  parameter int COORD_W    = 6,
  parameter int DATA_W     = 3,
  parameter int STARVE_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  output logic               disp_gnt,
  output logic               disp_valid,
  output logic [DATA_W-1:0]  disp_data,
  input  logic               pl_req,
  input  logic [COORD_W-1:0] pl_x,
  input  logic [COORD_W-1:0] pl_y,
  output logic               pl_gnt,
  output logic               pl_valid,
  output logic [DATA_W-1:0]  pl_data,
  input  logic               gh_req,
  input  logic [COORD_W-1:0] gh_x,
  input  logic [COORD_W-1:0] gh_y,
  output logic               gh_gnt,
  output logic               gh_valid,
  output logic [DATA_W-1:0]  gh_data,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               busy
);

  typedef enum logic [1:0] {SEL_NONE, SEL_DISP, SEL_PL, SEL_GH} sel_t;

  sel_t sel;
  logic rr_gh;     // 0: player wins the next player/ghost tie, 1: ghost
  logic pl_cand;
  logic gh_cand;

  // Player and ghost are masked during their grant cycle, so a held request
  // with not-yet-updated coordinates cannot be read twice. The display is a
  // streaming reader that advances its coordinates as soon as it sees gnt,
  // so it stays eligible every cycle and can sustain one read per cycle.
  assign pl_cand = pl_req && !pl_gnt;
  assign gh_cand = gh_req && !gh_gnt;

`ifdef BOARD_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] pl_cnt;
  logic [CNT_W-1:0] gh_cnt;
  logic             pl_starve;
  logic             gh_starve;

  assign pl_starve = pl_cand && (pl_cnt == CNT_MAX);
  assign gh_starve = gh_cand && (gh_cnt == CNT_MAX);
`endif

  always_comb begin
    sel = SEL_NONE;
    if (disp_req)                  sel = SEL_DISP;
    else if (pl_cand && gh_cand)   sel = rr_gh ? SEL_GH : SEL_PL;
    else if (pl_cand)              sel = SEL_PL;
    else if (gh_cand)              sel = SEL_GH;
`ifdef BOARD_ARB_STARVE_EN
    // A saturated counter overrides the normal order, display included.
    if (pl_starve && gh_starve)    sel = rr_gh ? SEL_GH : SEL_PL;
    else if (pl_starve)            sel = SEL_PL;
    else if (gh_starve)            sel = SEL_GH;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_x      <= '0;
      mem_y      <= '0;
      disp_gnt   <= 1'b0;
      pl_gnt     <= 1'b0;
      gh_gnt     <= 1'b0;
      disp_valid <= 1'b0;
      pl_valid   <= 1'b0;
      gh_valid   <= 1'b0;
      disp_data  <= '0;
      pl_data    <= '0;
      gh_data    <= '0;
      busy       <= 1'b0;
      rr_gh      <= 1'b0;
`ifdef BOARD_ARB_STARVE_EN
      pl_cnt     <= '0;
      gh_cnt     <= '0;
`endif
    end else begin
      disp_gnt <= (sel == SEL_DISP);
      pl_gnt   <= (sel == SEL_PL);
      gh_gnt   <= (sel == SEL_GH);
      busy     <= (sel != SEL_NONE);

      case (sel)
        SEL_DISP: begin mem_x <= disp_x; mem_y <= disp_y; end
        SEL_PL:   begin mem_x <= pl_x;   mem_y <= pl_y;   end
        SEL_GH:   begin mem_x <= gh_x;   mem_y <= gh_y;   end
        default:  ;
      endcase

      // Pointer moves to the other client after any player or ghost grant.
      if (sel == SEL_PL) rr_gh <= 1'b1;
      if (sel == SEL_GH) rr_gh <= 1'b0;

      // The address driven in the grant cycle returns data now.
      disp_valid <= disp_gnt;
      pl_valid   <= pl_gnt;
      gh_valid   <= gh_gnt;
      if (disp_gnt) disp_data <= mem_data;
      if (pl_gnt)   pl_data   <= mem_data;
      if (gh_gnt)   gh_data   <= mem_data;

`ifdef BOARD_ARB_STARVE_EN
      // A masked (just granted) request neither counts nor clears.
      if (!pl_req || sel == SEL_PL)          pl_cnt <= '0;
      else if (pl_cand && pl_cnt != CNT_MAX) pl_cnt <= pl_cnt + 1'b1;

      if (!gh_req || sel == SEL_GH)          gh_cnt <= '0;
      else if (gh_cand && gh_cnt != CNT_MAX) gh_cnt <= gh_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_board_port_arbiter.sv
// tb/tb_board_port_arbiter.sv - directed self-checking bench for board_port_arbiter

module tb_board_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_req, pl_req, gh_req;
  logic [5:0] disp_x, disp_y, pl_x, pl_y, gh_x, gh_y;
  logic       disp_gnt, disp_valid, pl_gnt, pl_valid, gh_gnt, gh_valid;
  logic [2:0] disp_data, pl_data, gh_data;
  logic [5:0] mem_x, mem_y;
  logic [2:0] mem_data;
  logic       busy;
  logic       md_fixed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Board model: fixed cell 2 in the first scenario, otherwise x ^ y (low 3 bits).
  assign mem_data = md_fixed ? 3'd2 : (mem_x[2:0] ^ mem_y[2:0]);

  board_port_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_data(disp_data),
    .pl_req(pl_req), .pl_x(pl_x), .pl_y(pl_y),
    .pl_gnt(pl_gnt), .pl_valid(pl_valid), .pl_data(pl_data),
    .gh_req(gh_req), .gh_x(gh_x), .gh_y(gh_y),
    .gh_gnt(gh_gnt), .gh_valid(gh_valid), .gh_data(gh_data),
    .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; md_fixed = 1'b0;
    disp_req = 0; pl_req = 0; gh_req = 0;
    disp_x = 0; disp_y = 0; pl_x = 0; pl_y = 0; gh_x = 0; gh_y = 0;
    step(); step();
    chk("rst_mem_x", mem_x, 0);
    chk("rst_mem_y", mem_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnts", {disp_gnt, pl_gnt, gh_gnt}, 0);
    chk("rst_valids", {disp_valid, pl_valid, gh_valid}, 0);
    chk("rst_data", {disp_data, pl_data, gh_data}, 0);
    reset = 1'b1;
    step();

    // Single player read at (4,7), board returns 2.
    md_fixed = 1'b1; pl_req = 1; pl_x = 4; pl_y = 7;
    step();
    chk("p1_pl_gnt", pl_gnt, 1);
    chk("p1_mem_x", mem_x, 4);
    chk("p1_mem_y", mem_y, 7);
    chk("p1_busy", busy, 1);
    chk("p1_other_gnt", {disp_gnt, gh_gnt}, 0);
    pl_req = 0;
    step();
    chk("p1_pl_valid", pl_valid, 1);
    chk("p1_pl_data", pl_data, 2);
    chk("p1_pl_gnt_pulse", pl_gnt, 0);
    chk("p1_busy_idle", busy, 0);
    chk("p1_other_valid", {disp_valid, gh_valid}, 0);
    step();
    chk("p1_valid_pulse", pl_valid, 0);
    chk("p1_data_hold", pl_data, 2);
    md_fixed = 1'b0;

    // Reset in the cycle after a grant discards the access.
    pl_req = 1; pl_x = 9; pl_y = 10;
    step();
    chk("rs_pl_gnt", pl_gnt, 1);
    pl_req = 0; reset = 1'b0;
    step();
    chk("rs_pl_valid", pl_valid, 0);
    chk("rs_pl_data", pl_data, 0);
    chk("rs_busy", busy, 0);
    chk("rs_pl_gnt", pl_gnt, 0);
    reset = 1'b1;

    // Player and ghost both held: alternate P,G,P,G (pointer = player after reset).
    pl_req = 1; pl_x = 1; pl_y = 2; gh_req = 1; gh_x = 3; gh_y = 5;
    step();
    chk("rr1_gnts", {pl_gnt, gh_gnt}, 2'b10);
    chk("rr1_mem", {mem_x, mem_y}, {6'd1, 6'd2});
    step();
    chk("rr2_gnts", {pl_gnt, gh_gnt}, 2'b01);
    chk("rr2_mem", {mem_x, mem_y}, {6'd3, 6'd5});
    chk("rr2_pl_valid", pl_valid, 1);
    chk("rr2_pl_data", pl_data, 3);
    chk("rr2_busy", busy, 1);
    pl_x = 6; pl_y = 1;
    step();
    chk("rr3_gnts", {pl_gnt, gh_gnt}, 2'b10);
    chk("rr3_mem", {mem_x, mem_y}, {6'd6, 6'd1});
    chk("rr3_gh_valid", gh_valid, 1);
    chk("rr3_gh_data", gh_data, 6);
    gh_x = 2; gh_y = 2;
    step();
    chk("rr4_gnts", {pl_gnt, gh_gnt}, 2'b01);
    chk("rr4_pl_data", {pl_valid, pl_data}, {1'b1, 3'd7});
    pl_req = 0; gh_req = 0;
    step();
    chk("rr5_gh_data", {gh_valid, gh_data}, {1'b1, 3'd0});
    chk("rr5_no_gnt", {disp_gnt, pl_gnt, gh_gnt}, 0);
    chk("rr5_busy", busy, 0);
    step();

    // Display and ghost together: display first, ghost next, no data crossover.
    disp_req = 1; disp_x = 5; disp_y = 3; gh_req = 1; gh_x = 7; gh_y = 0;
    step();
    chk("dg1_gnts", {disp_gnt, gh_gnt}, 2'b10);
    chk("dg1_mem", {mem_x, mem_y}, {6'd5, 6'd3});
    disp_req = 0;
    step();
    chk("dg2_gnts", {disp_gnt, gh_gnt}, 2'b01);
    chk("dg2_disp_data", {disp_valid, disp_data}, {1'b1, 3'd6});
    gh_req = 0;
    step();
    chk("dg3_gh_data", {gh_valid, gh_data}, {1'b1, 3'd7});
    chk("dg3_disp_hold", {disp_valid, disp_data}, {1'b0, 3'd6});
    step();

    // Ghost request withdrawn in the cycle display wins.
    disp_req = 1; disp_x = 0; disp_y = 4; gh_req = 1; gh_x = 1; gh_y = 1;
    step();
    chk("wd1_gnts", {disp_gnt, gh_gnt}, 2'b10);
`ifdef BOARD_ARB_STARVE_EN
    chk("wd1_gh_cnt", dut.gh_cnt, 1);
`endif
    disp_req = 0; gh_req = 0;
    step();
    chk("wd2_gh_gnt", gh_gnt, 0);
    chk("wd2_disp_data", {disp_valid, disp_data}, {1'b1, 3'd4});
`ifdef BOARD_ARB_STARVE_EN
    chk("wd2_gh_cnt", dut.gh_cnt, 0);
`endif
    step();
    chk("wd3_gh_valid", gh_valid, 0);
    chk("wd3_gh_data_hold", gh_data, 7);
    step();

    // Display held continuously with a pending player request.
    disp_req = 1; disp_x = 2; disp_y = 3; pl_req = 1; pl_x = 3; pl_y = 3;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("st_lost_disp", disp_gnt, 1);
      chk("st_lost_pl", pl_gnt, 0);
    end
    step();
`ifdef BOARD_ARB_STARVE_EN
    chk("st_forced_pl", {disp_gnt, pl_gnt}, 2'b01);
    chk("st_forced_mem", {mem_x, mem_y}, {6'd3, 6'd3});
    pl_req = 0;
    step();
    chk("st_resume_disp", {disp_gnt, pl_gnt}, 2'b10);
    chk("st_pl_data", {pl_valid, pl_data}, {1'b1, 3'd0});
    step();
    chk("st_resume_disp2", {disp_gnt, pl_gnt}, 2'b10);
`else
    for (int i = 0; i < 5; i++) begin
      chk("st_never_pl", {disp_gnt, pl_gnt}, 2'b10);
      step();
    end
`endif
    disp_req = 0; pl_req = 0;
    step(); step();
    chk("end_busy", busy, 0);
    chk("end_gnts", {disp_gnt, pl_gnt, gh_gnt}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_port_arbiter.md
Name: board_port_arbiter

Overview:
- Shares the single combinational board read port of board_state (x, y -> board_data) among three requesters: display renderer, player-move legality check, ghost-move AI.
- Pipelined: one grant per cycle; each grant returns data one cycle after the address is driven.
- Sits between board_state and the display, player and ghost controllers in the Pac-Man top level.

Parameters:
- COORD_W, 6, width of x/y coordinates.
- DATA_W, 3, width of a board cell code.
- STARVE_MAX, 15, consecutive lost cycles before a pending player/ghost request is forced through.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- disp_req  in  1  display read request.
- disp_x, disp_y  in  COORD_W each  display cell coordinate.
- disp_gnt  out  1  display request accepted this cycle.
- disp_valid  out  1  disp_data valid, one-cycle pulse.
- disp_data  out  DATA_W  returned cell.
- pl_req / pl_x / pl_y / pl_gnt / pl_valid / pl_data  same as display, for the player controller.
- gh_req / gh_x / gh_y / gh_gnt / gh_valid / gh_data  same as display, for the ghost controller.
- mem_x, mem_y  out  COORD_W each  registered address to board_state x/y.
- mem_data  in  DATA_W  board_data from board_state (combinational from mem_x/mem_y).
- busy  out  1  an access is in flight.

Behaviour:
- Reset (reset==0 at a clk edge):
  - mem_x, mem_y, all *_data = 0.
  - All *_gnt, *_valid, busy = 0.
  - Starvation counters = 0; round-robin pointer = player.
  - Any in-flight access is discarded with no valid pulse.
- Handshake:
  - Requester holds req and coordinates stable until its gnt.
  - gnt is a one-cycle registered pulse.
  - After gnt, the requester is masked from arbitration until its valid cycle ends.
  - Requester may keep req high for back-to-back reads, changing coordinates in the valid cycle.
- Pipeline (edge N grants client C):
  - After N: mem_x/mem_y = C's coordinates, C_gnt=1, busy=1.
  - Edge N+1: mem_data is captured into C_data.
  - After N+1: C_valid=1 for one cycle.
  - Request-to-valid latency is 2 cycles. A different client may be granted at edge N+1, giving one access per cycle sustained.
- Arbitration, among unmasked requesters each cycle:
  - Starvation override: a player/ghost counter equal to STARVE_MAX wins. If both are at max, the round-robin pointer decides.
  - Otherwise display wins if requesting.
  - Otherwise round-robin between player and ghost. The pointer toggles to the other client after any player or ghost grant.
- Starvation counters (player, ghost):
  - Increment, saturating at STARVE_MAX, each cycle the client requests unmasked and is not granted.
  - Clear on the client's grant or when its req is low.
- No grant cycle: mem_x/mem_y hold; busy=0 once the last valid has been issued.
- A req deasserted before gnt is withdrawn cleanly: no gnt, no valid.
- *_data holds its last captured value between valid pulses.

Optional Feature:
- Macro BOARD_ARB_STARVE_EN.
- Defined: starvation override active as above.
- Undefined: no counters; strict priority display > round-robin(player, ghost); STARVE_MAX is unused.

Test Plan:
- Reset released, mem_data=3'd2, pl_req=1 at (4,7):
  - pl_gnt and mem_x=4/mem_y=7 one cycle after sampling.
  - pl_valid=1 with pl_data=2 the next cycle.
  - No disp/gh activity.
- pl_req and gh_req both held continuously, display idle: grants alternate player, ghost, player, ghost; one valid per cycle after the 2-cycle fill.
- disp_req held continuously, pl_req=1, BOARD_ARB_STARVE_EN defined: player granted exactly once after 15 lost cycles, then display resumes. With the macro undefined, the player is never granted.
- Simultaneous disp_req and gh_req in the same cycle, no starvation: display granted first, ghost granted the following cycle. gh_data reflects gh coordinates, disp_data reflects disp coordinates, no crossover.
- reset driven low the cycle after pl_gnt: no pl_valid, pl_data=0, busy=0. After release, a fresh pl_req completes normally.
- gh_req pulsed high then dropped in the same cycle display wins: no gh_gnt, no gh_valid; ghost starvation counter returns to 0.
